// File: rtl/hazard_forward_unit.sv
// Forwarding select and load-use hazard unit for the 5-stage in-order pipeline.
// Optional macro HFU_ZERO_REG_EN: register address 0 never matches (r0 hardwired to zero).
module hazard_forward_unit #(
  parameter int unsigned       REG_AW    = 5,
  parameter int unsigned       OPC_W     = 5,
  parameter logic [OPC_W-1:0]  OPC_LOAD  = OPC_W'(5'b01010),
  parameter logic [OPC_W-1:0]  OPC_STORE = OPC_W'(5'b01011),
  parameter int unsigned       LOAD_LAT  = 1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [OPC_W-1:0]  id_opc,
  input  logic [REG_AW-1:0] id_ra1,
  input  logic [REG_AW-1:0] id_ra2,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic [OPC_W-1:0]  ex_opc,
  input  logic [REG_AW-1:0] ex_wa,
  input  logic [REG_AW-1:0] ex_ra2,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_wa,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [1:0]        fwd_sd_sel,
  output logic              fwd_sd_mem,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic [CNT_W-1:0]  stall_cnt
);

`ifdef HFU_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  localparam logic [2:0] LatInit = 3'(LOAD_LAT - 1);

  typedef enum logic {StRun, StStall} state_e;

  state_e           state_q, state_d;
  logic [2:0]       lat_cnt_q, lat_cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, fwd_sd_q, fwd_sd_d;
  logic             sd_mem_q, sd_mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_wr, mem_wr, ra1_ok, ra2_ok, sd_ok;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic id_store, ex_load, hazard, stall, sel_ok;
  logic [1:0] sel_a, sel_b;

  // Nearest producer wins: EX result is in MEM next cycle (01), MEM result is in WB (10).
  function automatic logic [1:0] sel_enc(input logic ex_hit, input logic mem_hit);
    return ex_hit ? 2'b01 : (mem_hit ? 2'b10 : 2'b00);
  endfunction

  always_comb begin
    ex_wr     = ex_valid & ex_we;
    mem_wr    = mem_valid & mem_we;
    ra1_ok    = !ZeroReg || (id_ra1 != '0);
    ra2_ok    = !ZeroReg || (id_ra2 != '0);
    sd_ok     = !ZeroReg || (ex_ra2 != '0);
    ex_hit_a  = ex_wr & (ex_wa == id_ra1) & ra1_ok;
    ex_hit_b  = ex_wr & (ex_wa == id_ra2) & ra2_ok;
    mem_hit_a = mem_wr & (mem_wa == id_ra1) & ra1_ok;
    mem_hit_b = mem_wr & (mem_wa == id_ra2) & ra2_ok;
    id_store  = (id_opc == OPC_STORE);
    ex_load   = ex_wr & (ex_opc == OPC_LOAD);
    // Store data from a load is forwarded later in MEM, so it never stalls.
    hazard    = ex_load & id_valid & (ex_hit_a | (ex_hit_b & !id_store));
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    stall     = 1'b0;
    unique case (state_q)
      StRun: begin
        if (hazard) begin
          stall = 1'b1;
          if (LOAD_LAT > 1 && !hold) begin
            state_d   = StStall;
            lat_cnt_d = LatInit;
          end
        end
      end
      StStall: begin
        stall = 1'b1;
        if (!hold) begin
          if (lat_cnt_q <= 3'd1) begin
            state_d = StRun;
          end else begin
            lat_cnt_d = lat_cnt_q - 3'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    sel_ok   = id_valid & !stall;
    sel_a    = sel_enc(ex_hit_a, mem_hit_a);
    sel_b    = sel_enc(ex_hit_b, mem_hit_b);
    fwd_a_d  = sel_ok ? sel_a : 2'b00;
    fwd_b_d  = (sel_ok & !id_store) ? sel_b : 2'b00;
    fwd_sd_d = (sel_ok & id_store) ? sel_b : 2'b00;
    sd_mem_d = ex_valid & (ex_opc == OPC_STORE) & mem_wr & (mem_wa == ex_ra2) & sd_ok;
    cnt_d    = cnt_q;
    if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      lat_cnt_q <= '0;
      fwd_a_q   <= '0;
      fwd_b_q   <= '0;
      fwd_sd_q  <= '0;
      sd_mem_q  <= 1'b0;
      cnt_q     <= '0;
    end else if (!hold) begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
      fwd_sd_q  <= fwd_sd_d;
      sd_mem_q  <= sd_mem_d;
      cnt_q     <= cnt_d;
    end
  end

  // Gated by reset so the Mealy outputs also drop while reset is asserted.
  assign stall_id   = stall & rst_n;
  assign bubble_ex  = stall & rst_n;
  assign fwd_a_sel  = fwd_a_q;
  assign fwd_b_sel  = fwd_b_q;
  assign fwd_sd_sel = fwd_sd_q;
  assign fwd_sd_mem = sd_mem_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: one LOAD_LAT=1 instance and one LOAD_LAT=3 instance.
module tb_hazard_forward_unit;

`ifdef HFU_ZERO_REG_EN
  localparam bit ZeroEn = 1'b1;
`else
  localparam bit ZeroEn = 1'b0;
`endif

  localparam logic [4:0] OpAdd   = 5'b00001;
  localparam logic [4:0] OpSub   = 5'b00010;
  localparam logic [4:0] OpLoad  = 5'b01010;
  localparam logic [4:0] OpStore = 5'b01011;

  logic       clk, rst_n, hold;
  logic       id_valid, ex_valid, ex_we, mem_valid, mem_we;
  logic [4:0] id_opc, id_ra1, id_ra2, ex_opc, ex_wa, ex_ra2, mem_wa;

  logic [1:0]  a1, b1, sd1, a3, b3, sd3;
  logic        sdm1, sdm3, stall1, stall3, bub1, bub3;
  logic [15:0] cnt1;
  logic [2:0]  cnt3;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [13:0] exp_q[$];

  hazard_forward_unit dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .id_valid(id_valid), .id_opc(id_opc), .id_ra1(id_ra1), .id_ra2(id_ra2),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_opc(ex_opc), .ex_wa(ex_wa), .ex_ra2(ex_ra2),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_wa(mem_wa),
    .fwd_a_sel(a1), .fwd_b_sel(b1), .fwd_sd_sel(sd1), .fwd_sd_mem(sdm1),
    .stall_id(stall1), .bubble_ex(bub1), .stall_cnt(cnt1)
  );

  hazard_forward_unit #(.LOAD_LAT(3), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .id_valid(id_valid), .id_opc(id_opc), .id_ra1(id_ra1), .id_ra2(id_ra2),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_opc(ex_opc), .ex_wa(ex_wa), .ex_ra2(ex_ra2),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_wa(mem_wa),
    .fwd_a_sel(a3), .fwd_b_sel(b3), .fwd_sd_sel(sd3), .fwd_sd_mem(sdm3),
    .stall_id(stall3), .bubble_ex(bub3), .stall_cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_idle();
    hold = 1'b0;
    id_valid = 1'b0; id_opc = OpAdd; id_ra1 = '0; id_ra2 = '0;
    ex_valid = 1'b0; ex_we = 1'b0; ex_opc = OpAdd; ex_wa = '0; ex_ra2 = '0;
    mem_valid = 1'b0; mem_we = 1'b0; mem_wa = '0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] opc, input logic [4:0] r1,
                        input logic [4:0] r2);
    id_valid = v; id_opc = opc; id_ra1 = r1; id_ra2 = r2;
  endtask

  task automatic set_ex(input logic v, input logic we, input logic [4:0] opc,
                        input logic [4:0] wa, input logic [4:0] r2);
    ex_valid = v; ex_we = we; ex_opc = opc; ex_wa = wa; ex_ra2 = r2;
  endtask

  task automatic set_mem(input logic v, input logic we, input logic [4:0] wa);
    mem_valid = v; mem_we = we; mem_wa = wa;
  endtask

  // Expected {a,b,sd,sdm} per instance is queued with the stimulus and popped after the edge.
  task automatic tick(input string tag, input logic [6:0] e1, input logic [6:0] e3);
    string       t;
    logic [13:0] e;
    tag_q.push_back(tag);
    exp_q.push_back({e1, e3});
    @(posedge clk);
    #1;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check_eq({t, "/lat1"}, {25'b0, a1, b1, sd1, sdm1}, {25'b0, e[13:7]});
    check_eq({t, "/lat3"}, {25'b0, a3, b3, sd3, sdm3}, {25'b0, e[6:0]});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "/lat1"}, {a1, b1, sd1, sdm1, stall1, bub1, cnt1}, '0);
    check_eq({tag, "/lat3"}, {a3, b3, sd3, sdm3, stall3, bub3, cnt3}, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    #7;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic forwarding selects
    set_ex(1, 1, OpAdd, 5'd3, 5'd0); set_id(1, OpSub, 5'd3, 5'd4);
    tick("fwd_ex", 7'b01_00_00_0, 7'b01_00_00_0);
    set_ex(0, 0, OpAdd, 5'd0, 5'd0); set_mem(1, 1, 5'd3);
    tick("fwd_mem", 7'b10_00_00_0, 7'b10_00_00_0);
    set_ex(1, 1, OpAdd, 5'd3, 5'd0); set_id(1, OpAdd, 5'd3, 5'd3);
    tick("fwd_both", 7'b01_01_00_0, 7'b01_01_00_0);
    set_ex(0, 0, OpAdd, 5'd0, 5'd0); set_id(1, OpStore, 5'd1, 5'd3);
    tick("store_sd", 7'b00_00_10_0, 7'b00_00_10_0);
    set_ex(0, 1, OpAdd, 5'd3, 5'd0); set_mem(0, 1, 5'd3); set_id(1, OpAdd, 5'd3, 5'd3);
    tick("bubble_nomatch", 7'b0, 7'b0);
    set_ex(1, 1, OpAdd, 5'd3, 5'd0); set_id(0, OpAdd, 5'd3, 5'd3); set_mem(0, 0, 5'd0);
    tick("id_invalid", 7'b0, 7'b0);

    // r0 handling
    set_ex(1, 1, OpAdd, 5'd0, 5'd0); set_id(1, OpAdd, 5'd0, 5'd2);
    tick("r0_fwd", ZeroEn ? 7'b0 : 7'b01_00_00_0, ZeroEn ? 7'b0 : 7'b01_00_00_0);
    set_ex(1, 1, OpLoad, 5'd0, 5'd0);
    #1;
    check_eq("r0_stall", {31'b0, stall1}, {31'b0, !ZeroEn});
    set_idle();
    tick("idle", 7'b0, 7'b0);

    // Load-use, hold mid-stall on the LOAD_LAT=3 instance
    set_ex(1, 1, OpLoad, 5'd5, 5'd0); set_id(1, OpAdd, 5'd1, 5'd5);
    #1;
    check_eq("lu_stall/lat1", {30'b0, stall1, bub1}, 32'b11);
    check_eq("lu_stall/lat3", {30'b0, stall3, bub3}, 32'b11);
    tick("lu_c0", 7'b0, 7'b0);
    check_eq("lu_cnt1", {16'b0, cnt1}, 32'd1);
    set_ex(0, 1, OpLoad, 5'd5, 5'd0); set_mem(1, 1, 5'd5);
    #1;
    check_eq("lu_release/lat1", {31'b0, stall1}, 32'd0);
    check_eq("lu_still/lat3", {31'b0, stall3}, 32'd1);
    tick("lu_c1", 7'b00_10_00_0, 7'b0);
    hold = 1'b1; id_ra2 = 5'd7;
    #1;
    check_eq("hold_stall/lat3", {31'b0, stall3}, 32'd1);
    tick("hold_c0", 7'b00_10_00_0, 7'b0);
    tick("hold_c1", 7'b00_10_00_0, 7'b0);
    check_eq("hold_cnt3", {29'b0, cnt3}, 32'd2);
    hold = 1'b0; id_ra2 = 5'd5;
    #1;
    check_eq("post_hold/lat3", {31'b0, stall3}, 32'd1);
    tick("lu_c2", 7'b00_10_00_0, 7'b0);
    check_eq("lu_cnt3", {29'b0, cnt3}, 32'd3);
    check_eq("lu_cnt1_keep", {16'b0, cnt1}, 32'd1);
    #1;
    check_eq("lu_done/lat3", {31'b0, stall3}, 32'd0);
    tick("lu_c3", 7'b00_10_00_0, 7'b00_10_00_0);

    // Load followed by store of the loaded register
    set_idle();
    set_ex(1, 1, OpLoad, 5'd7, 5'd0); set_id(1, OpStore, 5'd2, 5'd7);
    #1;
    check_eq("ldst_nostall", {30'b0, stall1, stall3}, 32'd0);
    tick("ldst_c0", 7'b00_00_01_0, 7'b00_00_01_0);
    set_ex(1, 0, OpStore, 5'd0, 5'd7); set_mem(1, 1, 5'd7); set_id(0, OpAdd, 5'd0, 5'd0);
    tick("ldst_c1", 7'b00_00_00_1, 7'b00_00_00_1);
    set_idle();
    tick("ldst_c2", 7'b0, 7'b0);

    // Reset during STALL
    set_ex(1, 1, OpLoad, 5'd5, 5'd0); set_id(1, OpAdd, 5'd1, 5'd5);
    tick("rst_c0", 7'b0, 7'b0);
    set_ex(0, 1, OpLoad, 5'd5, 5'd0); set_mem(1, 1, 5'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    set_ex(1, 1, OpLoad, 5'd5, 5'd0); set_mem(0, 0, 5'd0);
    #1;
    check_eq("rst_rehaz/lat3", {31'b0, stall3}, 32'd1);
    tick("rst_c1", 7'b0, 7'b0);
    check_eq("rst_cnt3a", {29'b0, cnt3}, 32'd1);
    set_ex(0, 1, OpLoad, 5'd5, 5'd0); set_mem(1, 1, 5'd5);
    tick("rst_c2", 7'b00_10_00_0, 7'b0);
    tick("rst_c3", 7'b00_10_00_0, 7'b0);
    check_eq("rst_cnt3b", {29'b0, cnt3}, 32'd3);
    check_eq("rst_stall_end", {31'b0, stall3}, 32'd0);

    // Continuous hazard: LOAD_LAT=3 counter (3 bits) saturates
    set_ex(1, 1, OpLoad, 5'd5, 5'd0); set_mem(0, 0, 5'd0);
    for (int i = 0; i < 10; i++) tick("sat", 7'b0, 7'b0);
    check_eq("sat_cnt3", {29'b0, cnt3}, 32'd7);
    check_eq("sat_cnt1", {16'b0, cnt1}, 32'd11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised forwarding and hazard unit for the in-order 5-stage pipeline (IF/ID/EX/MEM/WB).
- Compares ID-stage source registers against EX/MEM destinations every cycle and registers mux selects for the EX operand and store-data paths.
- Detects load-use hazards and runs a stall FSM that freezes IF/ID for LOAD_LAT cycles while bubbling EX.
- Forwards load data into a following store's data in MEM, and counts stall cycles.

Parameters:
- REG_AW, 5, register address width
- OPC_W, 5, opcode field width (IR[31:31-OPC_W+1])
- OPC_LOAD, 5'b01010, load opcode
- OPC_STORE, 5'b01011, store opcode
- LOAD_LAT, 1, stall cycles per load-use hazard (1..7)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global pipeline hold (memory wait); freezes all state
- id_valid  in  1  ID instruction valid
- id_opc  in  OPC_W  ID opcode
- id_ra1, id_ra2  in  REG_AW  ID source registers
- ex_valid, ex_we  in  1  EX valid / writes register
- ex_opc  in  OPC_W  EX opcode
- ex_wa, ex_ra2  in  REG_AW  EX destination / store-data source
- mem_valid, mem_we  in  1  MEM valid / writes register
- mem_wa  in  REG_AW  MEM destination
- fwd_a_sel  out  2  EX operand A: 00 regfile, 01 MEM result, 10 WB result
- fwd_b_sel  out  2  EX operand B, same encoding
- fwd_sd_sel  out  2  EX store-data select, same encoding
- fwd_sd_mem  out  1  MEM store data taken from WB result
- stall_id  out  1  freeze PC and IF/ID
- bubble_ex  out  1  insert NOP into ID/EX
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset is asynchronous (rst_n low): all outputs 0, FSM in RUN, counters 0. Reset mid-stall aborts the stall immediately.
- Match definitions:
  - Match1(r) = ex_valid & ex_we & ex_wa==r.
  - Match2(r) = mem_valid & mem_we & mem_wa==r.
- Select priority: Match1 gives 01 (producer is in MEM next cycle). Otherwise Match2 gives 10. Otherwise 00. The nearest producer always wins.
- Operand mapping:
  - id_ra1 drives fwd_a_sel.
  - id_ra2 drives fwd_sd_sel if id_opc==OPC_STORE, else fwd_b_sel. The unused select is 00.
- Select registers:
  - Update at posedge when hold=0 and stall_id=0, registering values computed from the current ID contents. They are valid the cycle the ID instruction is in EX.
  - If id_valid=0, or the cycle is a stall cycle, they load 00 (the bubble needs no forwarding).
- fwd_sd_mem is registered: set when ex_opc==OPC_STORE & ex_valid & mem-stage load (mem_we, mem_wa==ex_ra2 & mem_valid). This is evaluated as the load/store pair advances. No stall is needed for load-to-store-data.
- Load-use hazard: ex_valid & ex_opc==OPC_LOAD & ex_we & id_valid & (ex_wa==id_ra1 | (ex_wa==id_ra2 & id_opc!=OPC_STORE)).
- FSM has states RUN and STALL.
  - RUN: stall_id and bubble_ex are combinational (Mealy) on hazard detect. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1.
  - STALL: stall_id=bubble_ex=1. cnt decrements each non-hold cycle and returns to RUN when cnt reaches 1.
  - LOAD_LAT=1: a single stall cycle in RUN, with no STALL entry.
- After the stall, the consumer re-evaluates against the load now in MEM or WB and gets select 01 or 10 accordingly.
- hold=1: all registers including the FSM and counters keep their values. stall_id and bubble_ex still reflect the current state and detection.
- stall_cnt increments on every cycle with stall_id=1 & hold=0, and saturates at all-ones.
- Bubble inputs (valid=0) never match.

Optional Feature:
- HFU_ZERO_REG_EN defined: a source or destination address of 0 never matches. r0 is never forwarded and never causes a stall.
- Undefined: r0 is treated as an ordinary register.

Test Plan:
- ADD r3 in EX, ID SUB reads r3 as ra1 → next cycle fwd_a_sel=01. Same producer in MEM instead → fwd_a_sel=10. Producers in both EX and MEM → 01.
- LOAD r5 in EX, ID ADD ra2=r5, LOAD_LAT=1 → stall_id=bubble_ex=1 for exactly 1 cycle. Consumer then gets fwd_b_sel=01→ re-evaluated 10 per pipeline position. stall_cnt=1.
- LOAD_LAT=3, same hazard, with hold=1 pulsed for 2 cycles mid-stall → stall lasts 3 non-hold cycles, stall_cnt=3.
- LOAD r7 then STORE with data r7 → no stall. When the store is in MEM, fwd_sd_mem=1 for 1 cycle. fwd_b_sel stays 00.
- rst_n low during STALL → all outputs 0 asynchronously. First hazard after release is handled normally.
- HFU_ZERO_REG_EN: ex_wa=0 with ex_we=1 and id_ra1=0 → fwd_a_sel=00, no stall. Without the macro → 01.
